tx_framer: RTL and testbench



---
 rtl/tx_framer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_tx_framer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// tx_framer: HDLC-style Econet transmit framer, one line bit per netclk.
// Flags, bit-stuffed LSB-first payload, CRC-16/X-25 FCS, closing flag, aborts.
//
// Ports:
//   netclk      network bit clock, rising edge
//   reset       synchronous active-low reset
//   start       request a new frame (IDLE only)
//   data_in     payload byte
//   data_valid  data_in valid
//   data_last   data_in is the final payload byte
//   data_ready  holding register empty
//   abort_req   abandon the current frame
//   txdata      registered serial line data
//   tx_en       registered line driver enable
//   busy        high in every state except IDLE
//   frame_done  pulse after the last closing-flag bit
//   underrun    pulse when an abort is caused by an empty holding register
module tx_framer #(
  parameter int unsigned OPEN_FLAGS = 1,
  parameter int unsigned ABORT_ONES = 8
) (
  input  logic       netclk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  input  logic       abort_req,
  output logic       txdata,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_DATA,
    S_FCS,
    S_CLOSE,
    S_ABORT
  } state_t;

  localparam logic [7:0]  FLAG      = 8'h7E;
  localparam logic [15:0] POLY      = 16'h8408;
  localparam logic [4:0]  ABORT_N   = 5'(ABORT_ONES);
  localparam logic [3:0]  FLAG_LAST = 4'(OPEN_FLAGS - 1);

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        hold_last_q, hold_last_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [2:0]  ones_q, ones_d;
  logic        last_q, last_d;
  logic [15:0] crc_q, crc_d;
  logic        txdata_q, txdata_d;
  logic        tx_en_q, tx_en_d;
  logic        done_q, done_d;
  logic        urun_q, urun_d;

  logic        accept;
  logic        byte_avail;
  logic [7:0]  byte_nxt;
  logic        last_nxt;
  logic [15:0] fcs_w;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic [15:0] s;
    s = {1'b0, c[15:1]};
    if (c[0] ^ b) s = s ^ POLY;
    return s;
  endfunction

  // A byte offered on the same edge the shifter empties is
  // forwarded straight from data_in.
  assign accept     = data_valid && !hold_full_q;
  assign byte_avail = hold_full_q || data_valid;
  assign byte_nxt   = hold_full_q ? hold_q : data_in;
  assign last_nxt   = hold_full_q ? hold_last_q : data_last;
  assign fcs_w      = ~crc_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    sh_d        = sh_q;
    bcnt_d      = bcnt_q;
    fcnt_d      = fcnt_q;
    ones_d      = ones_q;
    last_d      = last_q;
    crc_d       = crc_q;
    txdata_d    = 1'b1;
    tx_en_d     = 1'b1;
    done_d      = 1'b0;
    urun_d      = 1'b0;

    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
      hold_last_d = data_last;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_en_d = 1'b0;
        if (start) begin
          state_d  = S_OPEN;
          txdata_d = FLAG[0];
          tx_en_d  = 1'b1;
          bcnt_d   = 5'd1;
          fcnt_d   = 4'd0;
          ones_d   = 3'd0;
          crc_d    = 16'hFFFF;
        end
      end

      S_OPEN: begin
        ones_d = 3'd0;
        if (abort_req) begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          hold_full_d = 1'b0;
        end else if (bcnt_q < 5'd8) begin
          txdata_d = FLAG[bcnt_q[2:0]];
          bcnt_d   = bcnt_q + 5'd1;
        end else if (fcnt_q != FLAG_LAST) begin
          fcnt_d   = fcnt_q + 4'd1;
          txdata_d = FLAG[0];
          bcnt_d   = 5'd1;
        end else if (byte_avail) begin
          state_d     = S_DATA;
          txdata_d    = byte_nxt[0];
          sh_d        = {9'd0, byte_nxt[7:1]};
          bcnt_d      = 5'd1;
          last_d      = last_nxt;
          hold_full_d = 1'b0;
          crc_d       = crc_step(crc_q, byte_nxt[0]);
          ones_d      = byte_nxt[0] ? 3'd1 : 3'd0;
        end else begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          hold_full_d = 1'b0;
          urun_d      = 1'b1;
        end
      end

      S_DATA: begin
        if (abort_req) begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          ones_d      = 3'd0;
          hold_full_d = 1'b0;
        end else if (ones_q == 3'd5) begin
          // stuffed zero: shifter stalls for this bit
          txdata_d = 1'b0;
          ones_d   = 3'd0;
        end else if (bcnt_q < 5'd8) begin
          txdata_d = sh_q[0];
          sh_d     = {1'b0, sh_q[15:1]};
          bcnt_d   = bcnt_q + 5'd1;
          crc_d    = crc_step(crc_q, sh_q[0]);
          ones_d   = sh_q[0] ? ones_q + 3'd1 : 3'd0;
        end else if (last_q) begin
          state_d  = S_FCS;
          txdata_d = fcs_w[0];
          sh_d     = {1'b0, fcs_w[15:1]};
          bcnt_d   = 5'd1;
          ones_d   = fcs_w[0] ? ones_q + 3'd1 : 3'd0;
        end else if (byte_avail) begin
          txdata_d    = byte_nxt[0];
          sh_d        = {9'd0, byte_nxt[7:1]};
          bcnt_d      = 5'd1;
          last_d      = last_nxt;
          hold_full_d = 1'b0;
          crc_d       = crc_step(crc_q, byte_nxt[0]);
          ones_d      = byte_nxt[0] ? ones_q + 3'd1 : 3'd0;
        end else begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          ones_d      = 3'd0;
          hold_full_d = 1'b0;
          urun_d      = 1'b1;
        end
      end

      S_FCS: begin
        if (abort_req) begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          ones_d      = 3'd0;
          hold_full_d = 1'b0;
        end else if (ones_q == 3'd5) begin
          txdata_d = 1'b0;
          ones_d   = 3'd0;
        end else if (bcnt_q < 5'd16) begin
          txdata_d = sh_q[0];
          sh_d     = {1'b0, sh_q[15:1]};
          bcnt_d   = bcnt_q + 5'd1;
          ones_d   = sh_q[0] ? ones_q + 3'd1 : 3'd0;
        end else begin
          state_d  = S_CLOSE;
          txdata_d = FLAG[0];
          bcnt_d   = 5'd1;
          ones_d   = 3'd0;
        end
      end

      S_CLOSE: begin
        if (abort_req) begin
          state_d     = S_ABORT;
          bcnt_d      = 5'd1;
          hold_full_d = 1'b0;
        end else if (bcnt_q < 5'd8) begin
          txdata_d = FLAG[bcnt_q[2:0]];
          bcnt_d   = bcnt_q + 5'd1;
        end else begin
          state_d = S_IDLE;
          tx_en_d = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_ABORT: begin
        ones_d = 3'd0;
        if (bcnt_q < ABORT_N) begin
          bcnt_d = bcnt_q + 5'd1;
        end else begin
          state_d = S_IDLE;
          tx_en_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge netclk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      sh_q        <= 16'd0;
      bcnt_q      <= 5'd0;
      fcnt_q      <= 4'd0;
      ones_q      <= 3'd0;
      last_q      <= 1'b0;
      crc_q       <= 16'hFFFF;
      txdata_q    <= 1'b1;
      tx_en_q     <= 1'b0;
      done_q      <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      sh_q        <= sh_d;
      bcnt_q      <= bcnt_d;
      fcnt_q      <= fcnt_d;
      ones_q      <= ones_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      txdata_q    <= txdata_d;
      tx_en_q     <= tx_en_d;
      done_q      <= done_d;
      urun_q      <= urun_d;
    end
  end

  assign txdata     = txdata_q;
  assign tx_en      = tx_en_q;
  assign busy       = (state_q != S_IDLE);
  assign data_ready = !hold_full_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: directed and randomized frames against a
// bit-level line model built from the framing rules.
module tb_tx_framer;

  localparam int OF = 1;
  localparam int AO = 8;

  logic       netclk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       abort_req = 1'b0;
  logic       data_ready;
  logic       txdata;
  logic       tx_en;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int ncmp = 0;
  int nfail = 0;

  bit         got[$];
  bit         exp_q[$];
  logic [7:0] pay[$];
  int         fd_cnt;
  int         ur_cnt;
  int         first_cyc;
  bit         tmo;
  logic       rst_tx, rst_en, rst_rdy, rst_busy;

  tx_framer #(
    .OPEN_FLAGS(OF),
    .ABORT_ONES(AO)
  ) dut (
    .netclk    (netclk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_ready(data_ready),
    .abort_req (abort_req),
    .txdata    (txdata),
    .tx_en     (tx_en),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always #5 netclk = ~netclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_line(input string tag);
    int bad;
    int n;
    bad = -1;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && got[i] != exp_q[i]) bad = i;
    if (bad < 0 && got.size() != exp_q.size()) bad = n;
    ncmp++;
    assert (bad < 0) else begin
      nfail++;
      $error("FAIL %s: line differs at bit %0d, got len %0d expected len %0d",
             tag, bad, got.size(), exp_q.size());
    end
  endtask

  // CRC-16/X-25 over the payload, returned already complemented
  function automatic logic [15:0] model_fcs();
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (pay[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ pay[i][k];
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return ~c;
  endfunction

  // Expected line bits while tx_en is high; fcs2 is the line
  // index of the second FCS bit.
  task automatic build_exp(input bit give_last, output int fcs2);
    bit raw[$];
    int ones;
    logic [15:0] f;
    logic [7:0] fl;
    exp_q.delete();
    fl = 8'h7E;
    repeat (OF) for (int k = 0; k < 8; k++) exp_q.push_back(fl[k]);
    foreach (pay[i]) for (int k = 0; k < 8; k++) raw.push_back(pay[i][k]);
    if (give_last) begin
      f = model_fcs();
      for (int k = 0; k < 16; k++) raw.push_back(f[k]);
    end
    ones = 0;
    fcs2 = -1;
    foreach (raw[i]) begin
      if (i == pay.size() * 8 + 1) fcs2 = exp_q.size();
      exp_q.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    if (give_last)
      for (int k = 0; k < 8; k++) exp_q.push_back(fl[k]);
    else
      repeat (AO) exp_q.push_back(1'b1);
  endtask

  task automatic trunc_exp(input int last_idx);
    while (exp_q.size() > last_idx + 1) void'(exp_q.pop_back());
  endtask

  task automatic run_frame(input int nb, input bit give_last,
                           input int abort_pos, input int start_len,
                           input int reset_pos);
    int idx;
    bit pend;
    int cyc;
    bit seen;
    int pos;
    idx = 0;
    cyc = 0;
    seen = 0;
    got.delete();
    fd_cnt = 0;
    ur_cnt = 0;
    first_cyc = -1;
    tmo = 0;
    @(negedge netclk);
    start = 1'b1;
    abort_req = 1'b0;
    data_valid = (nb > 0);
    data_in = pay[0];
    data_last = give_last && nb == 1;
    pend = data_valid && data_ready;
    while (1) begin
      @(negedge netclk);
      cyc++;
      if (tx_en) begin
        if (!seen) first_cyc = cyc;
        seen = 1;
        got.push_back(txdata);
      end
      if (frame_done) fd_cnt++;
      if (underrun) ur_cnt++;
      if (seen && !busy && !tx_en) break;
      if (cyc > 1000) begin
        tmo = 1;
        break;
      end
      if (pend) idx++;
      data_valid = idx < nb;
      data_in = (idx < nb) ? pay[idx] : 8'h00;
      data_last = give_last && idx == nb - 1;
      pos = got.size() - 1;
      start = (cyc < start_len) ||
              (abort_pos >= 0 && pos > abort_pos && pos <= abort_pos + 3);
      abort_req = abort_pos >= 0 && pos == abort_pos && tx_en;
      if (reset_pos >= 0 && pos == reset_pos) begin
        reset = 1'b0;
        data_valid = 1'b0;
        start = 1'b0;
        @(negedge netclk);
        rst_tx = txdata;
        rst_en = tx_en;
        rst_rdy = data_ready;
        rst_busy = busy;
        reset = 1'b1;
        break;
      end
      pend = data_valid && data_ready;
    end
    start = 1'b0;
    data_valid = 1'b0;
    data_last = 1'b0;
    abort_req = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    bit act;
    act = 0;
    repeat (12) begin
      @(negedge netclk);
      if (tx_en || busy) act = 1;
    end
    chk(tag, act, 0);
  endtask

  task automatic post(input string tag, input int efd, input int eur);
    chk_line({tag, "_line"});
    chk({tag, "_done"}, fd_cnt, efd);
    chk({tag, "_urun"}, ur_cnt, eur);
    chk({tag, "_tmo"}, tmo, 0);
    idle_check({tag, "_idle"});
  endtask

  task automatic rand_pay(input int n, input bit low7);
    pay.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0: b = 8'hFF;
        1: b = 8'h7E;
        default: b = 8'($urandom);
      endcase
      if (low7) b[7] = 1'b0;
      pay.push_back(b);
    end
  endtask

  initial begin
    int p;
    int nb;
    reset = 1'b0;
    repeat (3) @(negedge netclk);
    chk("rst_txdata", txdata, 1);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_urun", underrun, 0);
    reset = 1'b1;
    @(negedge netclk);

    pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
            8'h36, 8'h37, 8'h38, 8'h39};
    build_exp(1, p);
    run_frame(9, 1, -1, 1, -1);
    chk("check_lat", first_cyc, 1);
    post("check", 1, 0);

    pay = '{8'hFF};
    build_exp(1, p);
    run_frame(1, 1, -1, 1, -1);
    post("ff", 1, 0);

    pay = '{8'h7E};
    build_exp(1, p);
    run_frame(1, 1, -1, 1, -1);
    post("7e", 1, 0);

    for (int t = 0; t < 6; t++) begin
      nb = $urandom_range(1, 5);
      rand_pay(nb, 0);
      build_exp(1, p);
      run_frame(nb, 1, -1, 1, -1);
      post("rand", 1, 0);
    end

    rand_pay(2, 1);
    build_exp(0, p);
    run_frame(2, 0, -1, 1, -1);
    post("under", 0, 1);

    rand_pay(2, 0);
    build_exp(1, p);
    trunc_exp(p);
    repeat (AO) exp_q.push_back(1'b1);
    run_frame(2, 1, p, 1, -1);
    post("abort", 0, 0);

    rand_pay(3, 0);
    build_exp(1, p);
    p = 8 * OF + 4;
    trunc_exp(p);
    run_frame(3, 1, -1, 1, p);
    chk_line("mid_rst_line");
    chk("mid_rst_tx", rst_tx, 1);
    chk("mid_rst_en", rst_en, 0);
    chk("mid_rst_rdy", rst_rdy, 1);
    chk("mid_rst_busy", rst_busy, 0);
    chk("mid_rst_done", fd_cnt, 0);
    idle_check("mid_rst_idle");

    rand_pay(2, 0);
    build_exp(1, p);
    run_frame(2, 1, -1, 5, -1);
    post("start_open", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
